vector_overlay_scheduler: RTL and testbench

//  Sequences the vector overlay: tracks raster position, splits it into VECTOR_BOX_WIDTH boxes and

---
 rtl/vector_overlay_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_vector_overlay_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_overlay_scheduler.sv
// Raster tracker and double-buffered row prefetcher for the vector overlay display path.
// Optional macro VEC_CLAMP_EN folds the most-negative vector component to its symmetric value on write.
module vector_overlay_scheduler #(
  parameter int VECTOR_BOX_WIDTH = 32,
  parameter int CORD_WIDTH       = 5,
  parameter int BOX_COLS         = 20,
  parameter int BOX_ROWS         = 15,
  parameter int ADDR_WIDTH       = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    line_end,
  input  logic                    pix_valid,
  output logic                    vec_rd_req,
  output logic [ADDR_WIDTH-1:0]   vec_rd_addr,
  input  logic                    vec_rd_ack,
  input  logic                    vec_rd_valid,
  input  logic [2*CORD_WIDTH-1:0] vec_rd_data,
  output logic [CORD_WIDTH-1:0]   pixel_col,
  output logic [CORD_WIDTH-1:0]   pixel_row,
  output logic [CORD_WIDTH-1:0]   vec_x_cord,
  output logic [CORD_WIDTH-1:0]   vec_y_cord,
  output logic                    out_valid,
  output logic                    fetch_overrun
);

  // state  | meaning
  // S_IDLE | no fetch in progress
  // S_REQ  | read request held, waiting for ack
  // S_WAIT | read accepted, waiting for data
  // S_DONE | whole box row written into back bank

  localparam int BCW = (BOX_COLS > 1) ? $clog2(BOX_COLS) : 1;
  localparam int BRW = (BOX_ROWS > 1) ? $clog2(BOX_ROWS) : 1;
  localparam int IW  = $clog2(BOX_COLS + 1);
  localparam int DW  = 2 * CORD_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  logic [CORD_WIDTH-1:0] col_in_box_q, line_in_box_q;
  logic [BCW-1:0]        box_col_q;
  logic [BRW-1:0]        box_row_q;

  state_t                state_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [IW-1:0]         idx_q;
  logic                  tgt_q, active_q, row0_busy_q, overrun_q;
  logic [1:0]            discard_q, discard_d;
  logic [DW-1:0]         bank_q [2][BOX_COLS];

  logic [CORD_WIDTH-1:0] pixel_col_q, pixel_row_q, vec_x_q, vec_y_q;
  logic                  out_valid_q;

  logic                  busy, line_wrap, line_trig, data_ok, outstanding, discard_dec;
  logic [ADDR_WIDTH-1:0] next_row_base;
  logic [DW-1:0]         wr_data;

  always_comb begin
    busy          = (state_q == S_REQ) || (state_q == S_WAIT);
    line_wrap     = line_end && !frame_start &&
                    (line_in_box_q == CORD_WIDTH'(VECTOR_BOX_WIDTH - 1));
    line_trig     = line_end && !frame_start && (line_in_box_q == '0) &&
                    (box_row_q < BRW'(BOX_ROWS - 1));
    discard_dec   = vec_rd_valid && (discard_q != 2'd0);
    data_ok       = vec_rd_valid && (discard_q == 2'd0) && (state_q == S_WAIT);
    // A read still in flight when a fetch is abandoned must have its data dropped later.
    outstanding   = ((state_q == S_WAIT) && !data_ok) || ((state_q == S_REQ) && vec_rd_ack);
    discard_d     = discard_q - {1'b0, discard_dec} +
                    {1'b0, (frame_start || (line_wrap && busy)) && outstanding};
    next_row_base = ADDR_WIDTH'((32'(box_row_q) + 32'd1) * 32'(BOX_COLS));
    wr_data       = vec_rd_data;
`ifdef VEC_CLAMP_EN
    if (vec_rd_data[CORD_WIDTH-1:0] == {1'b1, {(CORD_WIDTH-1){1'b0}}})
      wr_data[CORD_WIDTH-1:0] = {1'b1, {(CORD_WIDTH-2){1'b0}}, 1'b1};
    if (vec_rd_data[DW-1:CORD_WIDTH] == {1'b1, {(CORD_WIDTH-1){1'b0}}})
      wr_data[DW-1:CORD_WIDTH] = {1'b1, {(CORD_WIDTH-2){1'b0}}, 1'b1};
`else
    wr_data       = vec_rd_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      col_in_box_q  <= '0;
      box_col_q     <= '0;
      line_in_box_q <= '0;
      box_row_q     <= '0;
    end else if (line_end) begin
      col_in_box_q <= '0;
      box_col_q    <= '0;
      if (line_in_box_q == CORD_WIDTH'(VECTOR_BOX_WIDTH - 1)) begin
        line_in_box_q <= '0;
        if (box_row_q < BRW'(BOX_ROWS - 1)) box_row_q <= box_row_q + 1'b1;
      end else begin
        line_in_box_q <= line_in_box_q + 1'b1;
      end
    end else if (pix_valid) begin
      if (col_in_box_q == CORD_WIDTH'(VECTOR_BOX_WIDTH - 1)) begin
        col_in_box_q <= '0;
        if (box_col_q < BCW'(BOX_COLS - 1)) box_col_q <= box_col_q + 1'b1;
      end else begin
        col_in_box_q <= col_in_box_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      idx_q       <= '0;
      tgt_q       <= 1'b0;
      active_q    <= 1'b0;
      row0_busy_q <= 1'b0;
      overrun_q   <= 1'b0;
      discard_q   <= '0;
      pixel_col_q <= '0;
      pixel_row_q <= '0;
      vec_x_q     <= '0;
      vec_y_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < BOX_COLS; i++) begin
        bank_q[0][i] <= '0;
        bank_q[1][i] <= '0;
      end
    end else begin
      discard_q   <= discard_d;
      out_valid_q <= pix_valid;
      if (pix_valid) begin
        pixel_col_q <= col_in_box_q;
        pixel_row_q <= line_in_box_q;
        if (row0_busy_q) begin
          vec_x_q   <= '0;
          vec_y_q   <= '0;
          overrun_q <= 1'b1;
        end else begin
          {vec_y_q, vec_x_q} <= bank_q[active_q][box_col_q];
        end
      end

      if (frame_start) begin
        state_q     <= S_REQ;
        req_q       <= 1'b1;
        addr_q      <= '0;
        idx_q       <= '0;
        tgt_q       <= 1'b0;
        active_q    <= 1'b0;
        row0_busy_q <= 1'b1;
        overrun_q   <= 1'b0;
      end else if (line_wrap) begin
        // A late fetch keeps the current bank on screen rather than a half-written one.
        if (busy) begin
          state_q     <= S_IDLE;
          req_q       <= 1'b0;
          row0_busy_q <= 1'b0;
          overrun_q   <= 1'b1;
        end else begin
          active_q <= ~active_q;
          if (state_q == S_DONE) state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (line_trig) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= next_row_base;
              idx_q   <= '0;
              tgt_q   <= ~active_q;
            end
          end
          S_REQ: begin
            if (vec_rd_ack) begin
              req_q   <= 1'b0;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (data_ok) begin
              bank_q[tgt_q][BCW'(idx_q)] <= wr_data;
              if (idx_q == IW'(BOX_COLS - 1)) begin
                state_q     <= S_DONE;
                row0_busy_q <= 1'b0;
              end else begin
                state_q <= S_REQ;
                req_q   <= 1'b1;
                addr_q  <= addr_q + 1'b1;
                idx_q   <= idx_q + 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign vec_rd_req    = req_q;
  assign vec_rd_addr   = addr_q;
  assign pixel_col     = pixel_col_q;
  assign pixel_row     = pixel_row_q;
  assign vec_x_cord    = vec_x_q;
  assign vec_y_cord    = vec_y_q;
  assign out_valid     = out_valid_q;
  assign fetch_overrun = overrun_q;

endmodule

// File: tb/tb_vector_overlay_scheduler.sv
// Directed bench for vector_overlay_scheduler: memory responder, address and pixel scoreboards.
module tb_vector_overlay_scheduler;

  logic       clk = 1'b0;
  logic       rst, frame_start, line_end, pix_valid;
  logic       vec_rd_req, vec_rd_ack, vec_rd_valid;
  logic [8:0] vec_rd_addr;
  logic [9:0] vec_rd_data;
  logic [4:0] pixel_col, pixel_row, vec_x_cord, vec_y_cord;
  logic       out_valid, fetch_overrun;

  int checks = 0;
  int failures = 0;

  int         exp_addr_q[$];
  logic [19:0] sb_q[$];

  int         mem_lat, mem_cnt, req_count;
  logic       mem_stall, mem_busy, data_mode;
  logic [9:0] mem_resp;

  vector_overlay_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_end(line_end),
    .pix_valid(pix_valid), .vec_rd_req(vec_rd_req), .vec_rd_addr(vec_rd_addr),
    .vec_rd_ack(vec_rd_ack), .vec_rd_valid(vec_rd_valid), .vec_rd_data(vec_rd_data),
    .pixel_col(pixel_col), .pixel_row(pixel_row), .vec_x_cord(vec_x_cord),
    .vec_y_cord(vec_y_cord), .out_valid(out_valid), .fetch_overrun(fetch_overrun)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks immediately, returns data mem_lat cycles after ack, checks addresses.
  initial begin
    vec_rd_ack = 1'b0; vec_rd_valid = 1'b0; vec_rd_data = '0;
    mem_busy = 1'b0; mem_cnt = 0; req_count = 0; mem_resp = '0;
    forever begin
      @(negedge clk);
      vec_rd_ack   = 1'b0;
      vec_rd_valid = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          vec_rd_valid = 1'b1;
          vec_rd_data  = mem_resp;
          mem_busy     = 1'b0;
        end
      end else if (vec_rd_req && !mem_stall) begin
        vec_rd_ack = 1'b1;
        req_count++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_req observed addr=%0d expected=no request", vec_rd_addr);
        end else begin
          check("rd_addr", 32'(vec_rd_addr), 32'(exp_addr_q.pop_front()));
        end
        mem_resp = data_mode ? 10'h210 : {5'd3, vec_rd_addr[4:0]};
        mem_cnt  = mem_lat;
        mem_busy = 1'b1;
      end
    end
  end

  // Pixel scoreboard consumer.
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_pixel observed col=%0d row=%0d expected=no output", pixel_col, pixel_row);
      end else begin
        check("pixel", 32'({pixel_col, pixel_row, vec_x_cord, vec_y_cord}), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic push_row(input int r);
    for (int i = 0; i < 20; i++) exp_addr_q.push_back(r * 20 + i);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic end_line(input int nidle);
    line_end = 1'b1;
    @(negedge clk);
    line_end = 1'b0;
    repeat (nidle) @(negedge clk);
  endtask

  // shown_row < 0 means the vector outputs are expected to be forced to zero.
  task automatic send_pixels(input int n, input int shown_row, input int lib);
    for (int p = 0; p < n; p++) begin
      int bc;
      logic [4:0] ex, ey;
      bc = (p / 32 > 19) ? 19 : p / 32;
      if (shown_row < 0) begin
        ex = 5'd0; ey = 5'd0;
      end else if (data_mode) begin
`ifdef VEC_CLAMP_EN
        ex = 5'b10001; ey = 5'b10001;
`else
        ex = 5'b10000; ey = 5'b10000;
`endif
      end else begin
        ex = 5'((shown_row * 20 + bc) % 32);
        ey = 5'd3;
      end
      sb_q.push_back({5'(p % 32), 5'(lib), ex, ey});
      pix_valid = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || mem_busy || vec_rd_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d cycles expected below %0d", tag, n, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; frame_start = 1'b0; line_end = 1'b0; pix_valid = 1'b0;
    mem_lat = 2; mem_stall = 1'b0; data_mode = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({pixel_col, pixel_row, vec_x_cord, vec_y_cord, out_valid, fetch_overrun}), 32'd0);
    check("rst_req", 32'(vec_rd_req), 32'd0);
    check("rst_addr", 32'(vec_rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    push_row(0);
    pulse_frame();
    check("fs_req", 32'(vec_rd_req), 32'd1);
    check("fs_addr", 32'(vec_rd_addr), 32'd0);
    wait_drain(500, "row0");
    check("row0_reads", 32'(req_count), 32'd20);
    check("row0_idle_req", 32'(vec_rd_req), 32'd0);

    for (int L = 0; L < 480; L++) begin
      if (L % 32 == 0 && L / 32 < 14) push_row(L / 32 + 1);
      if (L == 0 || L == 32) send_pixels(640, L / 32, L % 32);
      if (L == 479) send_pixels(200, 14, 31);
      end_line(3);
    end
    wait_drain(200, "frame");
    repeat (20) @(negedge clk);
    check("frame_overrun", 32'(fetch_overrun), 32'd0);
    check("frame_reads", 32'(req_count), 32'd300);

    mem_lat = 20;
    push_row(0);
    pulse_frame();
    wait_drain(2000, "row0_slow");
    push_row(1);
    for (int L = 0; L < 32; L++) end_line(3);
    exp_addr_q.delete();
    check("overrun_set", 32'(fetch_overrun), 32'd1);
    check("overrun_req_dropped", 32'(vec_rd_req), 32'd0);
    send_pixels(100, 0, 0);
    repeat (40) @(negedge clk);
    check("overrun_hold", 32'(fetch_overrun), 32'd1);
    push_row(0);
    pulse_frame();
    check("overrun_clear", 32'(fetch_overrun), 32'd0);
    send_pixels(1, -1, 0);
    check("row0_late_overrun", 32'(fetch_overrun), 32'd1);
    wait_drain(2000, "row0_refetch");

    push_row(0);
    pulse_frame();
    n = 0;
    while (exp_addr_q.size() > 14 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 2000) else begin
      failures++;
      $error("FAIL mid_fetch_timeout observed=%0d cycles expected below 2000", n);
    end
    repeat (2) @(negedge clk);
    exp_addr_q.delete();
    push_row(0);
    pulse_frame();
    check("restart_req", 32'(vec_rd_req), 32'd1);
    check("restart_addr", 32'(vec_rd_addr), 32'd0);
    wait_drain(2000, "restart");
    send_pixels(100, 0, 0);

    mem_stall = 1'b1;
    pulse_frame();
    check("stall_req", 32'(vec_rd_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_req", 32'(vec_rd_req), 32'd0);
    rst = 1'b0;
    mem_stall = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_req", 32'(vec_rd_req), 32'd0);

    data_mode = 1'b1;
    mem_lat = 2;
    push_row(0);
    pulse_frame();
    wait_drain(500, "clamp");
    send_pixels(40, 0, 0);
    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    check("addr_drain", 32'(exp_addr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
